// File: rtl/pc_gen_pkg.sv
// Shared PC-generator constants and FSM encoding, used by ROM, IF-ID and CSR logic.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pc_gen_pkg;

    localparam int          ADDR_WIDTH_DEF = 32;
    localparam logic [31:0] RESET_VEC_DEF  = 32'h0000_0000;
    localparam int unsigned INC_DEF        = 4;
    localparam int unsigned ALIGN_BITS_DEF = 2;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_RUN   = 2'd1,
        S_HALT  = 2'd2
    } pc_state_t;

endpackage

// File: rtl/pc_gen_next_sel.sv
// Next-PC priority mux (trap > jump > hold > increment) with target alignment and misalign detect.
// Latency: purely combinational.
// Backpressure: a non-accepted request or an external hold keeps the current PC.
module pc_next_sel
    import pc_gen_pkg::*;
#(
    parameter int          ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned INC        = INC_DEF,
    parameter int unsigned ALIGN_BITS = ALIGN_BITS_DEF
) (
    input  logic [ADDR_WIDTH-1:0] i_pc,
    input  logic                  i_ce,
    input  logic                  i_ready,
    input  logic                  i_hold,
    input  logic                  i_trap,
    input  logic [ADDR_WIDTH-1:0] i_trap_vec,
    input  logic                  i_jump,
    input  logic [ADDR_WIDTH-1:0] i_jump_addr,
    output logic [ADDR_WIDTH-1:0] o_next_pc,
    output logic                  o_redirect,
    output logic                  o_misalign
);

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << ALIGN_BITS;

    logic [ADDR_WIDTH-1:0] w_target_raw;
    logic                  w_advance;

    assign w_target_raw = i_trap ? i_trap_vec : i_jump_addr;
    assign o_redirect   = i_trap | i_jump;
    assign o_misalign   = o_redirect & (|(w_target_raw & ~ALIGN_MASK));
    assign w_advance    = i_ce & i_ready & ~i_hold;

    // Increment wraps modulo 2^ADDR_WIDTH by construction of the adder width.
    assign o_next_pc = o_redirect ? (w_target_raw & ALIGN_MASK) :
                       w_advance  ? (i_pc + ADDR_WIDTH'(INC))   :
                                    i_pc;

endmodule

// File: rtl/pc_gen.sv
// IF-stage program counter: issues fetch addresses over ce/ready with stall, halt and redirects.
// Latency: every input affects outputs one cycle later; all outputs are registered.
// Backpressure: while ce_o=1 and ready_i=0 the PC holds; a redirect replaces the pending request.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int          ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter logic [31:0] RESET_VEC  = RESET_VEC_DEF,
    parameter int unsigned INC        = INC_DEF,
    parameter int unsigned ALIGN_BITS = ALIGN_BITS_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stall_i,
    input  logic                  halt_i,
    input  logic                  jump_i,
    input  logic [ADDR_WIDTH-1:0] jump_addr_i,
    input  logic                  trap_i,
    input  logic [ADDR_WIDTH-1:0] trap_vec_i,
    input  logic                  ready_i,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic                  ce_o,
    output logic                  redirect_o,
    output logic                  misalign_o
);

    localparam logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(RESET_VEC);

    pc_state_t             r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_ce;
    logic                  r_redirect;
    logic                  r_misalign;

    logic [ADDR_WIDTH-1:0] w_next_pc;
    logic                  w_redirect;
    logic                  w_misalign;

    // Halt squashes the in-flight request, so resuming refetches the held address.
    pc_next_sel #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .INC        (INC),
        .ALIGN_BITS (ALIGN_BITS)
    ) u_next_sel (
        .i_pc        (r_pc),
        .i_ce        (r_ce),
        .i_ready     (ready_i),
        .i_hold      (stall_i | halt_i),
        .i_trap      (trap_i),
        .i_trap_vec  (trap_vec_i),
        .i_jump      (jump_i),
        .i_jump_addr (jump_addr_i),
        .o_next_pc   (w_next_pc),
        .o_redirect  (w_redirect),
        .o_misalign  (w_misalign)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_RESET;
            r_pc       <= RESET_PC;
            r_ce       <= 1'b0;
            r_redirect <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_pc       <= w_next_pc;
            r_redirect <= w_redirect;
            r_misalign <= w_misalign;
            case (r_state)
                S_RESET: begin
                    r_state <= S_RUN;
                    r_ce    <= 1'b1;
                end
                S_RUN: begin
                    if (halt_i && !w_redirect) begin
                        r_state <= S_HALT;
                        r_ce    <= 1'b0;
                    end else begin
                        r_ce    <= 1'b1;
                    end
                end
                S_HALT: begin
                    if (!halt_i) begin
                        r_state <= S_RUN;
                        r_ce    <= 1'b1;
                    end else begin
                        r_ce    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_RESET;
                    r_ce    <= 1'b0;
                end
            endcase
        end
    end

    assign pc_o       = r_pc;
    assign ce_o       = r_ce;
    assign redirect_o = r_redirect;
    assign misalign_o = r_misalign;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios with literal expectations plus random traffic.
// A behavioural model tracks the expected outputs and is compared on every falling edge.
module tb_pc_gen;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        stall_i = 1'b0;
    logic        halt_i = 1'b0;
    logic        jump_i = 1'b0;
    logic [31:0] jump_addr_i = '0;
    logic        trap_i = 1'b0;
    logic [31:0] trap_vec_i = '0;
    logic        ready_i = 1'b1;
    logic [31:0] pc_o;
    logic        ce_o;
    logic        redirect_o;
    logic        misalign_o;

    int n_cmp = 0;
    int n_bad = 0;

    // Model of the outputs as they should look after the most recent rising edge.
    bit          m_valid = 1'b0;
    bit          m_started = 1'b0;
    logic [31:0] exp_pc;
    logic        exp_ce;
    logic        exp_redir;
    logic        exp_mis;

    pc_gen dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .stall_i     (stall_i),
        .halt_i      (halt_i),
        .jump_i      (jump_i),
        .jump_addr_i (jump_addr_i),
        .trap_i      (trap_i),
        .trap_vec_i  (trap_vec_i),
        .ready_i     (ready_i),
        .pc_o        (pc_o),
        .ce_o        (ce_o),
        .redirect_o  (redirect_o),
        .misalign_o  (misalign_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, got, want, $time);
        end
    endtask

    // Expected next outputs, from the current expectation and the inputs just driven.
    task automatic model_step();
        logic [31:0] tgt;
        bit          redir;
        bit          running;
        if (rst_i) begin
            exp_pc = 32'h0; exp_ce = 1'b0; exp_redir = 1'b0; exp_mis = 1'b0;
            m_started = 1'b0;
        end else begin
            redir   = trap_i || jump_i;
            tgt     = trap_i ? trap_vec_i : jump_addr_i;
            running = exp_ce;
            if (redir)
                exp_pc = {tgt[31:2], 2'b00};
            else if (exp_ce && ready_i && !stall_i && !halt_i)
                exp_pc = exp_pc + 32'd4;
            exp_redir = redir;
            exp_mis   = redir && (tgt[1:0] != 2'b00);
            if (!m_started)
                exp_ce = 1'b1;
            else if (running)
                exp_ce = !(halt_i && !redir);
            else
                exp_ce = !halt_i;
            m_started = 1'b1;
        end
        m_valid = 1'b1;
    endtask

    always @(negedge clk_i) begin
        if (m_valid) begin
            chk("model_pc", pc_o, exp_pc);
            chk("model_ce", {31'b0, ce_o}, {31'b0, exp_ce});
            chk("model_redirect", {31'b0, redirect_o}, {31'b0, exp_redir});
            chk("model_misalign", {31'b0, misalign_o}, {31'b0, exp_mis});
        end
    end

    task automatic drive(input bit rst, input bit stall, input bit halt, input bit rdy,
                         input bit jmp, input logic [31:0] ja,
                         input bit trp, input logic [31:0] tv);
        @(negedge clk_i);
        #1;
        rst_i = rst; stall_i = stall; halt_i = halt; ready_i = rdy;
        jump_i = jmp; jump_addr_i = ja; trap_i = trp; trap_vec_i = tv;
        model_step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input bit rdy);
        drive(1'b0, 1'b0, 1'b0, rdy, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic lit(input string name, input logic [31:0] pc, input bit ce,
                       input bit rd, input bit mis);
        chk({name, "_pc"}, pc_o, pc);
        chk({name, "_ce"}, {31'b0, ce_o}, {31'b0, ce});
        chk({name, "_redir"}, {31'b0, redirect_o}, {31'b0, rd});
        chk({name, "_mis"}, {31'b0, misalign_o}, {31'b0, mis});
    endtask

    initial begin
        // Reset release and sequential fetch
        drive(1'b1, 0, 0, 1, 0, 0, 0, 0);
        drive(1'b1, 0, 0, 1, 0, 0, 0, 0);
        lit("reset", 32'h0, 0, 0, 0);
        idle(1); lit("first", 32'h0, 1, 0, 0);
        idle(1); lit("seq4", 32'h4, 1, 0, 0);
        idle(1); lit("seq8", 32'h8, 1, 0, 0);
        idle(1); lit("seqC", 32'hC, 1, 0, 0);
        idle(1); lit("seq10", 32'h10, 1, 0, 0);
        // Backpressure
        for (int i = 0; i < 3; i++) begin
            idle(0); lit("bp_hold", 32'h10, 1, 0, 0);
        end
        idle(1); lit("bp_release", 32'h14, 1, 0, 0);
        idle(1); idle(1); idle(1); lit("at20", 32'h20, 1, 0, 0);
        // Jump wins over stall
        drive(0, 1, 0, 1, 1, 32'h100, 0, 0); lit("jump_stall", 32'h100, 1, 1, 0);
        idle(1); lit("after_jump", 32'h104, 1, 0, 0);
        // Trap and jump together
        drive(0, 0, 0, 1, 1, 32'h200, 1, 32'h80); lit("trap_jump", 32'h80, 1, 1, 0);
        idle(1); lit("after_trap", 32'h84, 1, 0, 0);
        // Misaligned target
        drive(0, 0, 0, 1, 1, 32'h103, 0, 0); lit("misalign", 32'h100, 1, 1, 1);
        idle(1); lit("misalign_clr", 32'h104, 1, 0, 0);
        // Halt at top of address space, then wrap
        drive(0, 0, 0, 1, 1, 32'hFFFF_FFFC, 0, 0); lit("to_top", 32'hFFFF_FFFC, 1, 1, 0);
        drive(0, 0, 1, 1, 0, 0, 0, 0); lit("halt1", 32'hFFFF_FFFC, 0, 0, 0);
        drive(0, 0, 1, 1, 0, 0, 0, 0); lit("halt2", 32'hFFFF_FFFC, 0, 0, 0);
        idle(1); lit("resume", 32'hFFFF_FFFC, 1, 0, 0);
        idle(1); lit("wrap", 32'h0, 1, 0, 0);
        idle(1); lit("post_wrap", 32'h4, 1, 0, 0);
        // Redirect while halted, then reset mid-halt
        drive(0, 0, 1, 1, 0, 0, 0, 0); lit("halt3", 32'h4, 0, 0, 0);
        drive(0, 0, 1, 1, 1, 32'h40, 0, 0); lit("halt_jump", 32'h40, 0, 1, 0);
        idle(1); lit("halt_resume_tgt", 32'h40, 1, 0, 0);
        drive(0, 0, 1, 1, 0, 0, 0, 0); lit("halt4", 32'h40, 0, 0, 0);
        drive(1, 0, 1, 1, 0, 0, 0, 0); lit("rst_in_halt", 32'h0, 0, 0, 0);
        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] ja;
            logic [31:0] tv;
            ja = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            tv = $urandom;
            drive($urandom_range(0, 99) == 0,
                  $urandom_range(0, 5) == 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 9) == 0, ja,
                  $urandom_range(0, 15) == 0, tv);
        end
        @(negedge clk_i);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
